// File: rtl/pc_redirect.sv
// Fetch PC sequencer: redirects on registered branch decisions, flushes wrong-path slots, and traps on misaligned targets.
// Redirect takes effect one cycle after ex_* are presented; stall holds the PC except when a redirect is taken.
module pc_redirect #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          FLUSH_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic [31:0] ex_instr,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_rs1,
  input  logic        br,
  output logic [31:0] pc,
  output logic        pc_valid,
  output logic        flush,
  output logic        misalign
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, TRAP} state_t;

  localparam logic [2:0] CNT_INIT = 3'(FLUSH_DEPTH - 1);
  localparam bit         MULTI    = (FLUSH_DEPTH > 1);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] tgt_q, tgt_d;
  logic [2:0]  cnt_q;
  logic        vld_q, flush_q, mis_q;
  logic [31:0] pc_inc;

  assign pc_inc = pc_q + 32'd4;

  always_comb begin
    tgt_d = ex_pc + 32'd4;
    case (ex_instr[6:0])
      OP_BRANCH: tgt_d = ex_pc + {{19{ex_instr[31]}}, ex_instr[31], ex_instr[7],
                                  ex_instr[30:25], ex_instr[11:8], 1'b0};
      OP_JAL:    tgt_d = ex_pc + {{11{ex_instr[31]}}, ex_instr[31], ex_instr[19:12],
                                  ex_instr[20], ex_instr[30:21], 1'b0};
      OP_JALR:   tgt_d = (ex_rs1 + {{20{ex_instr[31]}}, ex_instr[31:20]}) & ~32'h1;
      default:   tgt_d = ex_pc + 32'd4;
    endcase
  end

  // Target is captured every cycle, independent of stall, so it lines up with br one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tgt_q <= 32'h0;
    else        tgt_q <= tgt_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      vld_q   <= 1'b0;
      flush_q <= 1'b0;
      mis_q   <= 1'b0;
      cnt_q   <= 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= RUN;
          vld_q   <= 1'b1;
        end
        RUN: begin
          if (br) begin
            if (tgt_q[1:0] == 2'b00) begin
              pc_q    <= tgt_q;
              flush_q <= 1'b1;
              cnt_q   <= CNT_INIT;
              state_q <= MULTI ? FLUSH : RUN;
            end else begin
              state_q <= TRAP;
              mis_q   <= 1'b1;
              vld_q   <= 1'b0;
              flush_q <= 1'b0;
            end
          end else begin
            flush_q <= 1'b0;
            if (!stall) pc_q <= pc_inc;
          end
        end
        FLUSH: begin
          // br here belongs to a squashed wrong-path instruction.
          if (!stall) begin
            pc_q <= pc_inc;
            if (cnt_q == 3'd0) begin
              state_q <= RUN;
              flush_q <= 1'b0;
            end else begin
              cnt_q   <= cnt_q - 3'd1;
              flush_q <= 1'b1;
            end
          end
        end
        TRAP: begin
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pc       = pc_q;
  assign pc_valid = vld_q;
  assign flush    = flush_q;
  assign misalign = mis_q;

endmodule
